// File: rtl/gcd_driver.sv
// Sequencer that feeds operand pairs to a serial GCD unit and returns the result.
// Handles zero operands locally and reports a timeout if the unit never completes.
//
// state  | meaning
// IDLE   | ready for a new operand pair
// START  | one-cycle start pulse to the GCD unit
// LOAD_A | first operand on gcd_data_in
// LOAD_B | second operand on gcd_data_in
// WAIT   | waiting for a gcd_done rising edge or timeout
// RESP   | result presented until the consumer takes it
module gcd_driver #(
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [SIZE-1:0] req_a,
    input  logic [SIZE-1:0] req_b,
    output logic            gcd_start,
    output logic [SIZE-1:0] gcd_data_in,
    input  logic [SIZE-1:0] gcd_data_out,
    input  logic            gcd_done,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SIZE-1:0] rsp_gcd,
    output logic            rsp_err,
    output logic            busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD_A,
        LOAD_B,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [CW-1:0]   cnt;
    logic            done_q;
    logic            done_rise;

    // Only a fresh edge counts, so a done left high by the previous op is not mistaken for completion.
    assign done_rise = gcd_done & ~done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            done_q      <= 1'b0;
            req_ready   <= 1'b1;
            gcd_start   <= 1'b0;
            gcd_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_gcd     <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done_q <= gcd_done;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        a_q       <= req_a;
                        b_q       <= req_b;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_a == '0 || req_b == '0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_gcd   <= req_a | req_b;
                            rsp_err   <= 1'b0;
                        end else begin
                            state     <= START;
                            gcd_start <= 1'b1;
                        end
                    end
                end
                START: begin
                    state       <= LOAD_A;
                    gcd_start   <= 1'b0;
                    gcd_data_in <= a_q;
                end
                LOAD_A: begin
                    state       <= LOAD_B;
                    gcd_data_in <= b_q;
                end
                LOAD_B: begin
                    state       <= WAIT;
                    gcd_data_in <= '0;
                    cnt         <= '0;
                end
                WAIT: begin
                    if (done_rise) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_gcd   <= gcd_data_out;
                        rsp_err   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_gcd   <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready   <= 1'b1;
                    gcd_start   <= 1'b0;
                    gcd_data_in <= '0;
                    rsp_valid   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver: handshakes, cycle timing, zero bypass,
// timeout, stale completion and reset abort.
module tb_gcd_driver;

    localparam int SIZE    = 8;
    localparam int TIMEOUT = 255;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [SIZE-1:0] req_a;
    logic [SIZE-1:0] req_b;
    logic            gcd_start;
    logic [SIZE-1:0] gcd_data_in;
    logic [SIZE-1:0] gcd_data_out;
    logic            gcd_done;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [SIZE-1:0] rsp_gcd;
    logic            rsp_err;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int start_count = 0;

    gcd_driver #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .gcd_start    (gcd_start),
        .gcd_data_in  (gcd_data_in),
        .gcd_data_out (gcd_data_out),
        .gcd_done     (gcd_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_gcd      (rsp_gcd),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (gcd_start === 1'b1) start_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({req_ready, gcd_start, gcd_data_in, rsp_valid, rsp_gcd, rsp_err, busy} !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values rdy=%b start=%b din=%0d vld=%b gcd=%0d err=%b busy=%b expected rdy=1 others 0",
                     req_ready, gcd_start, gcd_data_in, rsp_valid, rsp_gcd, rsp_err, busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int s0;
        s0 = start_count;
        rsp_ready = 1'b0;
        req_a = 8'd48; req_b = 8'd18; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got=%b exp=1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({gcd_start, gcd_data_in, req_ready, busy} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL basic_cycle1 start=%b din=%0d rdy=%b busy=%b exp start=1 din=0 rdy=0 busy=1", gcd_start, gcd_data_in, req_ready, busy);
        end
        tick();
        checks++;
        if ({gcd_start, gcd_data_in} !== {1'b0, 8'd48}) begin
            errors++; $display("FAIL basic_load_a start=%b din=%0d exp start=0 din=48", gcd_start, gcd_data_in);
        end
        tick();
        checks++;
        if (gcd_data_in !== 8'd18) begin errors++; $display("FAIL basic_load_b din=%0d exp=18", gcd_data_in); end
        tick();
        checks++;
        if ({gcd_data_in, rsp_valid, busy} !== {8'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL basic_wait din=%0d vld=%b busy=%b exp din=0 vld=0 busy=1", gcd_data_in, rsp_valid, busy);
        end
        repeat (4) tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early_rsp vld=%b exp=0", rsp_valid); end
        gcd_data_out = 8'd6; gcd_done = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, rsp_gcd, rsp_err, req_ready} !== {1'b1, 8'd6, 1'b0, 1'b0}) begin
            errors++; $display("FAIL basic_result vld=%b gcd=%0d err=%b rdy=%b exp vld=1 gcd=6 err=0 rdy=0", rsp_valid, rsp_gcd, rsp_err, req_ready);
        end
        gcd_data_out = 8'd77;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({rsp_valid, rsp_gcd, rsp_err, req_ready} !== {1'b1, 8'd6, 1'b0, 1'b0}) begin
                errors++; $display("FAIL hold_cycle%0d vld=%b gcd=%0d err=%b rdy=%b exp vld=1 gcd=6 err=0 rdy=0", i, rsp_valid, rsp_gcd, rsp_err, req_ready);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, busy} !== {1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL basic_back_idle vld=%b rdy=%b busy=%b exp vld=0 rdy=1 busy=0", rsp_valid, req_ready, busy);
        end
        checks++;
        if (start_count - s0 !== 1) begin errors++; $display("FAIL basic_start_pulses got=%0d exp=1", start_count - s0); end
    endtask

    // gcd_done is still high from test_basic when this request arrives.
    task automatic test_stale_done();
        req_a = 8'd20; req_b = 8'd8; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({rsp_valid, busy} !== {1'b0, 1'b1}) begin
                errors++; $display("FAIL stale_ignored_c%0d vld=%b busy=%b exp vld=0 busy=1", i + 5, rsp_valid, busy);
            end
        end
        gcd_done = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_fall vld=%b exp=0", rsp_valid); end
        gcd_data_out = 8'd4; gcd_done = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, rsp_gcd, rsp_err} !== {1'b1, 8'd4, 1'b0}) begin
            errors++; $display("FAIL stale_result vld=%b gcd=%0d err=%b exp vld=1 gcd=4 err=0", rsp_valid, rsp_gcd, rsp_err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        gcd_done = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        gcd_done = 1'b0;
        req_a = 8'd12; req_b = 8'd9; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (2 + TIMEOUT) tick();
        checks++;
        if ({rsp_valid, busy} !== {1'b0, 1'b1}) begin
            errors++; $display("FAIL timeout_last_wait vld=%b busy=%b exp vld=0 busy=1", rsp_valid, busy);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_gcd} !== {1'b1, 1'b1, 8'd0}) begin
            errors++; $display("FAIL timeout_result vld=%b err=%b gcd=%0d exp vld=1 err=1 gcd=0", rsp_valid, rsp_err, rsp_gcd);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 1'b1}) begin
            errors++; $display("FAIL timeout_idle vld=%b rdy=%b exp vld=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_zero_bypass();
        int s0;
        s0 = start_count;
        rsp_ready = 1'b1;
        req_a = 8'd0; req_b = 8'd35; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_gcd, rsp_err, gcd_start, req_ready} !== {1'b1, 8'd35, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL zero_0_35 vld=%b gcd=%0d err=%b start=%b rdy=%b exp vld=1 gcd=35 err=0 start=0 rdy=0",
                               rsp_valid, rsp_gcd, rsp_err, gcd_start, req_ready);
        end
        tick();
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 1'b1}) begin
            errors++; $display("FAIL zero_idle vld=%b rdy=%b exp vld=0 rdy=1", rsp_valid, req_ready);
        end
        req_a = 8'd0; req_b = 8'd0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_gcd, rsp_err} !== {1'b1, 8'd0, 1'b0}) begin
            errors++; $display("FAIL zero_0_0 vld=%b gcd=%0d err=%b exp vld=1 gcd=0 err=0", rsp_valid, rsp_gcd, rsp_err);
        end
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (start_count - s0 !== 0) begin errors++; $display("FAIL zero_no_start pulses=%0d exp=0", start_count - s0); end
    endtask

    task automatic test_reset_in_wait();
        req_a = 8'd9; req_b = 8'd6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if ({busy, gcd_data_in} !== {1'b1, 8'd0}) begin
            errors++; $display("FAIL rstw_in_wait busy=%b din=%0d exp busy=1 din=0", busy, gcd_data_in);
        end
        reset = 1'b1; rsp_ready = 1'b1;
        tick();
        reset = 1'b0; rsp_ready = 1'b0;
        checks++;
        if ({req_ready, busy, rsp_valid, gcd_start} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rstw_idle rdy=%b busy=%b vld=%b start=%b exp rdy=1 busy=0 vld=0 start=0", req_ready, busy, rsp_valid, gcd_start);
        end
        gcd_data_out = 8'd3; gcd_done = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rsp_valid, busy} !== {1'b0, 1'b0}) begin
            errors++; $display("FAIL rstw_no_rsp vld=%b busy=%b exp vld=0 busy=0", rsp_valid, busy);
        end
        gcd_done = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
        gcd_data_out = '0; gcd_done = 1'b0; rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_stale_done();
        test_timeout();
        test_zero_bypass();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
